// File: rtl/operate_uart_tx_pkg.sv
// Shared definitions for the operate UART transmit path: operate byte
// constants, the frame tag carried in bits [1:0], the shifter FSM encoding
// and a format check used by the input filter.
package operate_uart_tx_pkg;

  localparam logic [7:0] OPERATE_IGNORE   = 8'b1_00000_10;
  localparam logic [7:0] OPERATE_GET      = 8'b1_00001_10;
  localparam logic [7:0] OPERATE_PUT      = 8'b1_00010_10;
  localparam logic [7:0] OPERATE_INTERACT = 8'b1_00100_10;
  localparam logic [7:0] OPERATE_MOVE     = 8'b1_01000_10;
  localparam logic [7:0] OPERATE_THROW    = 8'b1_10000_10;

  localparam logic [1:0] OPERATE_FRAME_TAG = 2'b10;

  localparam int unsigned OPERATE_BYTE_W = 8;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Well-formed operate byte: leading 1 and the 2'b10 tag.
  function automatic logic is_well_formed(input logic [7:0] b);
    return b[7] && (b[1:0] == OPERATE_FRAME_TAG);
  endfunction

endpackage

// File: rtl/operate_uart_tx_if.sv
// Operate byte handshake from the verifier into the transmitter.
//   op_valid : byte offered this cycle
//   op_data  : operate byte {1, ooooo, 2'b10}
//   op_ready : transmitter can accept (FIFO not full)
interface operate_uart_tx_if;
  logic       op_valid;
  logic [7:0] op_data;
  logic       op_ready;

  modport master (output op_valid, output op_data, input op_ready);
  modport slave  (input op_valid, input op_data, output op_ready);
endinterface

// File: rtl/operate_tx_fifo.sv
// Synchronous first-word-fall-through byte FIFO.
//   push/wr_data : write when not full
//   pop/rd_data  : rd_data shows head entry; pop advances when not empty
//   full/empty   : from pointers carrying an extra wrap bit
//   level        : registered occupancy, 0..FIFO_DEPTH
module operate_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIDTH      = 8
) (
  input  logic                        uart_clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Same index with differing wrap bits means full.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer and occupancy registers.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + PW'(1);
        2'b01:   level <= level - PW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge uart_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/operate_uart_tx.sv
// Operate link UART transmitter: filters verified operate bytes, queues them
// and shifts them out as 8N1 frames (8E1 when OPERATE_TX_PARITY_EN is defined).
//   uart_clk, rst_n : clock, asynchronous active-low reset
//   op_bus          : operate byte handshake (slave side)
//   uart_tx         : registered serial line, idle high
//   tx_busy         : shifter not idle (aligned with the line)
//   fifo_level      : queued bytes
//   drop_pulse      : one-cycle pulse when an offered byte is discarded
module operate_uart_tx
  import operate_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        uart_clk,
  input  logic                        rst_n,
  operate_uart_tx_if.slave            op_bus,
  output logic                        uart_tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        drop_pulse
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e   state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [OPERATE_BYTE_W-1:0] shift_q, shift_d;
  logic        line_d;
  logic        baud_end;

  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [OPERATE_BYTE_W-1:0] fifo_rd_data;
  logic        accept, well_formed;

`ifdef OPERATE_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  // Input filter: IGNORE is swallowed silently, malformed or refused bytes pulse drop.
  assign op_bus.op_ready = ~fifo_full;
  assign accept          = op_bus.op_valid && op_bus.op_ready;
  assign well_formed     = is_well_formed(op_bus.op_data);
  assign fifo_push       = accept && well_formed && (op_bus.op_data != OPERATE_IGNORE);

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) drop_pulse <= 1'b0;
    else        drop_pulse <= op_bus.op_valid && (!op_bus.op_ready || !well_formed);
  end

  operate_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (OPERATE_BYTE_W)
  ) u_fifo (
    .uart_clk (uart_clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .wr_data  (op_bus.op_data),
    .pop      (fifo_pop),
    .rd_data  (fifo_rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign baud_end = (baud_q == BAUD_LAST);

  // Shifter state registers.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef OPERATE_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef OPERATE_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state: a frame is loaded from the FIFO head in IDLE or at the end of STOP.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
`ifdef OPERATE_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd_data;
          baud_d   = '0;
          bit_d    = '0;
          state_d  = TX_START;
`ifdef OPERATE_TX_PARITY_EN
          parity_d = ^fifo_rd_data;
`endif
        end
      end
      TX_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      TX_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[OPERATE_BYTE_W-1:1]};
          if (bit_q == 3'd7) begin
`ifdef OPERATE_TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef OPERATE_TX_PARITY_EN
      TX_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = TX_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      TX_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd_data;
            bit_d    = '0;
            state_d  = TX_START;
`ifdef OPERATE_TX_PARITY_EN
            parity_d = ^fifo_rd_data;
`endif
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Line level for the current state; registered below for a glitch-free output.
  always_comb begin
    line_d = 1'b1;
    case (state_q)
      TX_START:  line_d = 1'b0;
      TX_DATA:   line_d = shift_q[0];
`ifdef OPERATE_TX_PARITY_EN
      TX_PARITY: line_d = parity_q;
`endif
      default:   line_d = 1'b1;
    endcase
  end

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_tx <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      uart_tx <= line_d;
      tx_busy <= (state_q != TX_IDLE);
    end
  end

endmodule

// File: tb/tb_operate_uart_tx.sv
// Directed bench for operate_uart_tx; builds with or without OPERATE_TX_PARITY_EN.
module tb_operate_uart_tx;
  import operate_uart_tx_pkg::*;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef OPERATE_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic          uart_clk = 1'b0;
  logic          rst_n    = 1'b0;
  logic          uart_tx;
  logic          tx_busy;
  logic [LW-1:0] fifo_level;
  logic          drop_pulse;

  int passed = 0;
  int total  = 0;

  logic [7:0] burst [6];
  logic [7:0] bad   [3];

  operate_uart_tx_if op_if ();

  operate_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .uart_clk   (uart_clk),
    .rst_n      (rst_n),
    .op_bus     (op_if),
    .uart_tx    (uart_tx),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level),
    .drop_pulse (drop_pulse)
  );

  always #5 uart_clk = ~uart_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before 400000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected line level for frame bit j: start, 8 data LSB first, [parity], stop.
  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (FRAME_BITS == 11 && j == 9) return ^b;
    return 1'b1;
  endfunction

  // Called at the negedge showing frame cycle 'first'; returns at the cycle after the frame.
  task automatic check_frame(input string tag, input logic [7:0] b, input int first);
    for (int t = first; t < FRAME_BITS * CPB; t++) begin
      automatic int j = t / CPB;
      automatic int c = t % CPB;
      if (t == first || c == 0 || c == CPB - 1)
        chk($sformatf("%s bit%0d c%0d", tag, j, c), 32'(uart_tx), 32'(frame_bit(b, j)));
      if (t == first) chk({tag, " busy"}, 32'(tx_busy), 32'd1);
      @(negedge uart_clk);
    end
  endtask

  task automatic wait_start(input string tag);
    automatic int n = 0;
    while (uart_tx !== 1'b0 && n < 64) begin
      @(negedge uart_clk);
      n++;
    end
    chk({tag, " start seen"}, 32'(n < 64), 32'd1);
  endtask

  task automatic push_one(input logic [7:0] b);
    op_if.op_valid = 1'b1;
    op_if.op_data  = b;
    @(negedge uart_clk);
    op_if.op_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag, input int cycles);
    automatic logic stayed = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) stayed = 1'b0;
      @(negedge uart_clk);
    end
    chk({tag, " line idle"}, 32'(stayed), 32'd1);
  endtask

  initial begin
    op_if.op_valid = 1'b0;
    op_if.op_data  = '0;
    burst = '{OPERATE_GET, OPERATE_PUT, OPERATE_INTERACT, OPERATE_MOVE, OPERATE_THROW, OPERATE_GET};
    bad   = '{8'h00, 8'h06, 8'h87};

    // Reset values.
    repeat (3) @(negedge uart_clk);
    chk("rst uart_tx", 32'(uart_tx), 32'd1);
    chk("rst tx_busy", 32'(tx_busy), 32'd0);
    chk("rst op_ready", 32'(op_if.op_ready), 32'd1);
    chk("rst fifo_level", 32'(fifo_level), 32'd0);
    chk("rst drop_pulse", 32'(drop_pulse), 32'd0);
    rst_n = 1'b1;
    @(negedge uart_clk);

    // GET: start bit exactly two cycles after the accepting edge.
    push_one(OPERATE_GET);
    chk("get level", 32'(fifo_level), 32'd1);
    chk("get line n1", 32'(uart_tx), 32'd1);
    @(negedge uart_clk);
    chk("get line n2", 32'(uart_tx), 32'd1);
    @(negedge uart_clk);
    check_frame("get", OPERATE_GET, 0);
    chk("get end line", 32'(uart_tx), 32'd1);
    chk("get end busy", 32'(tx_busy), 32'd0);
    chk("get end level", 32'(fifo_level), 32'd0);

    // IGNORE is consumed silently.
    push_one(OPERATE_IGNORE);
    chk("ign drop", 32'(drop_pulse), 32'd0);
    chk("ign level", 32'(fifo_level), 32'd0);
    check_idle("ign", 24);

    // Malformed bytes pulse drop for one cycle and send nothing.
    for (int k = 0; k < 3; k++) begin
      push_one(bad[k]);
      chk($sformatf("bad%0d drop", k), 32'(drop_pulse), 32'd1);
      chk($sformatf("bad%0d level", k), 32'(fifo_level), 32'd0);
      @(negedge uart_clk);
      chk($sformatf("bad%0d drop off", k), 32'(drop_pulse), 32'd0);
      check_idle($sformatf("bad%0d", k), 20);
    end

    // Six back-to-back bytes into a depth-4 FIFO: one popped, four queued, one dropped.
    for (int k = 0; k < 6; k++) begin
      op_if.op_valid = 1'b1;
      op_if.op_data  = burst[k];
      if (k >= 1) begin
        chk($sformatf("burst level n%0d", k), 32'(fifo_level), (k < 2) ? 32'd1 : 32'(k - 1));
        chk($sformatf("burst drop n%0d", k), 32'(drop_pulse), 32'd0);
      end
      if (k == 5) chk("burst ready full", 32'(op_if.op_ready), 32'd0);
      @(negedge uart_clk);
    end
    op_if.op_valid = 1'b0;
    chk("burst drop 6th", 32'(drop_pulse), 32'd1);
    @(negedge uart_clk);
    chk("burst drop off", 32'(drop_pulse), 32'd0);
    chk("burst level full", 32'(fifo_level), 32'd4);
    check_frame("burst0", burst[0], 4);
    for (int k = 1; k < 5; k++) check_frame($sformatf("burst%0d", k), burst[k], 0);
    chk("burst end line", 32'(uart_tx), 32'd1);
    chk("burst end busy", 32'(tx_busy), 32'd0);
    chk("burst end level", 32'(fifo_level), 32'd0);

    // MOVE has three ones: parity bit 1 when parity is built in.
    push_one(OPERATE_MOVE);
    wait_start("move");
    check_frame("move", OPERATE_MOVE, 0);
    chk("move end line", 32'(uart_tx), 32'd1);
    chk("move end busy", 32'(tx_busy), 32'd0);

    // Reset during data bit 3 of THROW, with two more bytes queued.
    for (int k = 0; k < 3; k++) begin
      op_if.op_valid = 1'b1;
      op_if.op_data  = (k == 0) ? OPERATE_THROW : OPERATE_PUT;
      @(negedge uart_clk);
    end
    op_if.op_valid = 1'b0;
    wait_start("rst mid");
    repeat (4 * CPB + 6) @(negedge uart_clk);
    chk("pre rst line bit3", 32'(uart_tx), 32'd0);
    chk("pre rst busy", 32'(tx_busy), 32'd1);
    chk("pre rst level", 32'(fifo_level), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid rst line", 32'(uart_tx), 32'd1);
    chk("mid rst busy", 32'(tx_busy), 32'd0);
    chk("mid rst level", 32'(fifo_level), 32'd0);
    chk("mid rst ready", 32'(op_if.op_ready), 32'd1);
    @(negedge uart_clk);
    rst_n = 1'b1;
    @(negedge uart_clk);
    check_idle("post rst", 8);
    push_one(OPERATE_GET);
    wait_start("post rst");
    check_frame("post rst", OPERATE_GET, 0);
    chk("post rst end busy", 32'(tx_busy), 32'd0);
    chk("post rst end level", 32'(fifo_level), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
